// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer: walks a signed IMG_W x IMG_H feature map in 2x2,
// stride-2 windows. For each window it fetches four pixels from a read RAM,
// hands them to an external max unit and writes the pooled result to an
// output RAM. Optional build macro: POOL_RELU_EN (clamps negative results to 0).
module pool_window_sequencer #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8,
  parameter int RD_AW  = 6,
  parameter int WR_AW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [RD_AW-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pool_a,
  output logic [DATA_W-1:0] pool_b,
  output logic [DATA_W-1:0] pool_c,
  output logic [DATA_W-1:0] pool_d,
  output logic              pool_en,
  input  logic [DATA_W-1:0] pool_op,
  input  logic              pool_done,
  output logic              wr_en,
  output logic [WR_AW-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic [2:0] {IDLE, FETCH, LAST, POOL, WB, DONE} state_t;

  // Row/column counters share the read-address width so address math never truncates.
  localparam logic [RD_AW-1:0] ROW_PITCH = RD_AW'(IMG_W);
  localparam logic [RD_AW-1:0] LAST_COL  = RD_AW'(IMG_W - 2);
  localparam logic [RD_AW-1:0] LAST_ROW  = RD_AW'(IMG_H - 2);
  localparam logic [RD_AW-1:0] STEP      = RD_AW'(2);

  state_t             state_reg, state_next;
  logic [1:0]         k_reg, k_next;
  logic [RD_AW-1:0]   r_reg, r_next;
  logic [RD_AW-1:0]   c_reg, c_next;
  logic [WR_AW-1:0]   widx_reg, widx_next;
  logic [DATA_W-1:0]  a_reg, a_next, b_reg, b_next, c_pix_reg, c_pix_next, d_reg, d_next;
  logic [RD_AW-1:0]   row_sel, col_sel, fetch_addr;
  logic [DATA_W-1:0]  pooled_val;
  logic               last_window;

  // k selects the pixel: bit 1 picks the lower row, bit 0 the right column.
  assign row_sel     = r_reg + {{(RD_AW-1){1'b0}}, k_reg[1]};
  assign col_sel     = c_reg + {{(RD_AW-1){1'b0}}, k_reg[0]};
  assign fetch_addr  = row_sel * ROW_PITCH + col_sel;
  assign last_window = (r_reg == LAST_ROW) && (c_reg == LAST_COL);

`ifdef POOL_RELU_EN
  assign pooled_val = pool_op[DATA_W-1] ? '0 : pool_op;
`else
  assign pooled_val = pool_op;
`endif

  assign busy    = (state_reg != IDLE);
  assign wr_addr = widx_reg;
  assign pool_a  = a_reg;
  assign pool_b  = b_reg;
  assign pool_c  = c_pix_reg;
  assign pool_d  = d_reg;

  // State and datapath registers; reset aborts any pass in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      r_reg     <= '0;
      c_reg     <= '0;
      widx_reg  <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_pix_reg <= '0;
      d_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      r_reg     <= r_next;
      c_reg     <= c_next;
      widx_reg  <= widx_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      c_pix_reg <= c_pix_next;
      d_reg     <= d_next;
    end
  end

  // Next-state, pixel capture, window stepping and strobe generation.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    r_next     = r_reg;
    c_next     = c_reg;
    widx_next  = widx_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    c_pix_next = c_pix_reg;
    d_next     = d_reg;
    done       = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    pool_en    = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          k_next     = '0;
          r_next     = '0;
          c_next     = '0;
          widx_next  = '0;
        end
      end
      FETCH: begin
        rd_en   = 1'b1;
        rd_addr = fetch_addr;
        // Read data lags the address by one cycle, so capture trails k by one.
        case (k_reg)
          2'd1:    a_next     = rd_data;
          2'd2:    b_next     = rd_data;
          2'd3:    c_pix_next = rd_data;
          default: ;
        endcase
        k_next = k_reg + 2'd1;
        if (k_reg == 2'd3) state_next = LAST;
      end
      LAST: begin
        d_next     = rd_data;
        state_next = POOL;
      end
      POOL: begin
        pool_en    = 1'b1;
        state_next = WB;
      end
      WB: begin
        if (pool_done) begin
          wr_en     = 1'b1;
          wr_data   = pooled_val;
          widx_next = widx_reg + 1'b1;
          k_next    = '0;
          if (c_reg == LAST_COL) begin
            c_next = '0;
            r_next = (r_reg == LAST_ROW) ? '0 : r_reg + STEP;
          end else begin
            c_next = c_reg + STEP;
          end
          state_next = last_window ? DONE : FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Bench for pool_window_sequencer: behavioural RAMs and max units around an
// 8x8 instance and a 4x2 instance, with a window-level reference model.
module tb_pool_window_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start2;
  logic       busy, done, rd_en, pool_en, pool_done, wr_en;
  logic [5:0] rd_addr;
  logic [3:0] wr_addr;
  logic [7:0] rd_data, pool_a, pool_b, pool_c, pool_d, pool_op, wr_data;

  logic       busy2, done2, rd_en2, pool_en2, pool_done2, wr_en2;
  logic [2:0] rd_addr2;
  logic [0:0] wr_addr2;
  logic [7:0] rd_data2, pool_a2, pool_b2, pool_c2, pool_d2, pool_op2, wr_data2;

  pool_window_sequencer #(.IMG_W(8), .IMG_H(8), .DATA_W(8), .RD_AW(6), .WR_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_a(pool_a), .pool_b(pool_b), .pool_c(pool_c), .pool_d(pool_d),
    .pool_en(pool_en), .pool_op(pool_op), .pool_done(pool_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  pool_window_sequencer #(.IMG_W(4), .IMG_H(2), .DATA_W(8), .RD_AW(3), .WR_AW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .pool_a(pool_a2), .pool_b(pool_b2), .pool_c(pool_c2), .pool_d(pool_d2),
    .pool_en(pool_en2), .pool_op(pool_op2), .pool_done(pool_done2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int max4(input logic [7:0] a, b, c, d);
    int m;
    m = $signed(a);
    if ($signed(b) > m) m = $signed(b);
    if ($signed(c) > m) m = $signed(c);
    if ($signed(d) > m) m = $signed(d);
    return m;
  endfunction

  function automatic logic [7:0] expect_pool(input int m);
    int v;
    v = m;
`ifdef POOL_RELU_EN
    if (v < 0) v = 0;
`endif
    return 8'(v);
  endfunction

  // Input RAMs: registered read, data valid the cycle after rd_en.
  logic [7:0] mem  [0:63];
  logic [7:0] mem2 [0:7];
  always @(posedge clk) if (rd_en)  rd_data  <= mem[rd_addr];
  always @(posedge clk) if (rd_en2) rd_data2 <= mem2[rd_addr2];

  // Max units: result registered on pool_en, pool_done after extra_dly more cycles.
  int extra_dly = 0;
  int wait_cnt;
  bit pending;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_done <= 1'b0; pool_op <= '0; pending <= 1'b0; wait_cnt <= 0;
    end else begin
      pool_done <= 1'b0;
      if (pool_en) begin
        pool_op <= 8'(max4(pool_a, pool_b, pool_c, pool_d));
        if (extra_dly == 0) pool_done <= 1'b1;
        else begin pending <= 1'b1; wait_cnt <= extra_dly; end
      end else if (pending) begin
        if (wait_cnt == 1) begin pool_done <= 1'b1; pending <= 1'b0; end
        wait_cnt <= wait_cnt - 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_done2 <= 1'b0; pool_op2 <= '0;
    end else begin
      pool_done2 <= pool_en2;
      if (pool_en2) pool_op2 <= 8'(max4(pool_a2, pool_b2, pool_c2, pool_d2));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: expected writes for the 8x8 map, one entry per window in row-major order.
  int         exp_addr_q[$];
  logic [7:0] exp_data_q[$];
  int wr_count, done_count, first_wr_cyc, done_cyc, start_cyc, exp_total;
  int w2_addr[$];
  int w2_data[$];
  int done2_count = 0;

  task automatic build_ref();
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int r = 0; r < 8; r += 2)
      for (int c = 0; c < 8; c += 2) begin
        exp_addr_q.push_back((r / 2) * 4 + c / 2);
        exp_data_q.push_back(expect_pool(max4(mem[r*8+c], mem[r*8+c+1],
                                              mem[(r+1)*8+c], mem[(r+1)*8+c+1])));
      end
  endtask

  // Write / done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      int ea;
      logic [7:0] ed;
      wr_count++;
      if (wr_count == 1) first_wr_cyc = cyc;
      check_eq("wr_while_pool_done", pool_done, 1);
      if (exp_addr_q.size() == 0) begin
        check_eq("write_count_limit", wr_count, exp_total);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        $display("write %0d: addr=%0d data=%0d exp_addr=%0d exp_data=%0d",
                 wr_count, wr_addr, $signed(wr_data), ea, $signed(ed));
        check_eq("wr_addr", wr_addr, ea);
        check_eq("wr_data", wr_data, ed);
      end
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
      check_eq("busy_at_done", busy, 1);
    end
    if (wr_en2) begin
      w2_addr.push_back(wr_addr2);
      w2_data.push_back(wr_data2);
    end
    if (done2) done2_count++;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_pass(input int extra, input int restart_at);
    extra_dly = extra;
    build_ref();
    exp_total = 16; wr_count = 0; done_count = 0;
    pulse_start();
    for (int i = 1; i < 400 && done_count == 0; i++) begin
      @(posedge clk); #1;
      start = (i == restart_at);
    end
    start = 1'b0;
    if (done_count == 0) check_eq("done_timeout", done_count, 1);
    else begin
      check_eq("done_latency", done_cyc + 1 - start_cyc, 113 + 16 * extra);
      check_eq("first_wr_latency", first_wr_cyc + 1 - start_cyc, 7 + extra);
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("write_count", wr_count, 16);
    check_eq("done_pulses", done_count, 1);
    check_eq("ref_left", exp_addr_q.size(), 0);
    check_eq("busy_after", busy, 0);
    $display("pass extra=%0d restart_at=%0d writes=%0d done=%0d", extra, restart_at, wr_count, done_count);
  endtask

  task automatic check_idle_outputs(input string where);
    check_eq({where, "_busy"}, busy, 0);
    check_eq({where, "_rd_en"}, rd_en, 0);
    check_eq({where, "_rd_addr"}, rd_addr, 0);
    check_eq({where, "_pool_en"}, pool_en, 0);
    check_eq({where, "_wr_en"}, wr_en, 0);
    check_eq({where, "_wr_addr"}, wr_addr, 0);
    check_eq({where, "_wr_data"}, wr_data, 0);
    check_eq({where, "_pool_abcd"}, {pool_a, pool_b, pool_c, pool_d}, 0);
    check_eq({where, "_done"}, done, 0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 1);
  endtask

  initial begin
    logic [7:0] small_map [0:7];
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    small_map = '{8'd1, 8'hFE, 8'd3, 8'd4, 8'd5, 8'd6, 8'hF9, 8'd8};
    for (int i = 0; i < 8; i++) mem2[i] = small_map[i];
    load_ramp();
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    rst_n = 1'b1;

    // Ramp map, registered max unit.
    run_pass(0, 0);

    // Uniform -5 map.
    for (int i = 0; i < 64; i++) mem[i] = 8'hFB;
    run_pass(0, 0);

    // Slow max unit, then a stray start mid-pass.
    load_ramp();
    run_pass(3, 0);
    run_pass(0, 40);

    // Reset during the fifth window's fetch.
    build_ref();
    exp_total = 4; wr_count = 0; done_count = 0; extra_dly = 0;
    pulse_start();
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("midreset");
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (5) @(posedge clk);
    #1 check_eq("writes_before_reset", wr_count, 4);
    check_eq("done_after_reset", done_count, 0);
    rst_n = 1'b1;
    run_pass(0, 0);

    // 4x2 map: two windows.
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 0; i < 60 && done2_count == 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check_eq("small_writes", w2_addr.size(), 2);
    check_eq("small_done", done2_count, 1);
    if (w2_addr.size() == 2) begin
      $display("small: addr=%0d data=%0d, addr=%0d data=%0d", w2_addr[0], w2_data[0], w2_addr[1], w2_data[1]);
      check_eq("small_addr0", w2_addr[0], 0);
      check_eq("small_data0", w2_data[0], 6);
      check_eq("small_addr1", w2_addr[1], 1);
      check_eq("small_data1", w2_data[1], 8);
    end

    // Random maps with random max-unit latency.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
      run_pass(int'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
